// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// Request is held until a one-cycle ack returns read data.
interface mem_stage_if;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_ack, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_ack, dm_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: variable-latency load/store with timeout and MEM/WB register.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
   parameter int unsigned WAIT_LIMIT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mwreg,
   input  logic        mm2reg,
   input  logic        mwmem,
   input  logic [31:0] C_r,
   input  logic [31:0] mb,
   input  logic [4:0]  mrn,
   input  logic [31:0] minstr,
   mem_stage_if.master dm,
   output logic        mem_stall,
   output logic        wwreg,
   output logic        wm2reg,
   output logic [31:0] wmo,
   output logic [31:0] walu,
   output logic [4:0]  wrn,
   output logic [31:0] winstr,
   output logic        wbus_err,
   output logic        walign_err
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   localparam logic [7:0] LIM = 8'(WAIT_LIMIT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [31:0] buf_q;
   logic        err_q;
   logic        acc;
   logic        mis;

   assign acc = mm2reg | mwmem;

`ifdef MEM_ALIGN_CHECK_EN
   assign mis = |C_r[1:0];

   always_ff @(posedge clk) begin
      if (rst) walign_err <= 1'b0;
      else walign_err <= (state == IDLE) && acc && mis;
   end
`else
   assign mis = 1'b0;
   assign walign_err = 1'b0;
`endif

   assign mem_stall = ((state == IDLE) && acc && !mis)
                    || (state == WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         buf_q       <= '0;
         err_q       <= 1'b0;
         dm.dm_req   <= 1'b0;
         dm.dm_we    <= 1'b0;
         dm.dm_addr  <= '0;
         dm.dm_wdata <= '0;
         wwreg       <= 1'b0;
         wm2reg      <= 1'b0;
         wmo         <= '0;
         walu        <= '0;
         wrn         <= '0;
         winstr      <= '0;
         wbus_err    <= 1'b0;
      end else begin
         wbus_err <= 1'b0;
         unique case (state)
            IDLE: begin
               wmo  <= '0;
               walu <= C_r;
               wrn  <= mrn;
               if (acc && !mis) begin
                  wwreg       <= 1'b0;
                  wm2reg      <= 1'b0;
                  winstr      <= '0;
                  dm.dm_req   <= 1'b1;
                  dm.dm_we    <= mwmem;
                  dm.dm_addr  <= {C_r[31:2], 2'b00};
                  dm.dm_wdata <= mb;
                  cnt         <= '0;
                  err_q       <= 1'b0;
                  state       <= WAIT;
               end else begin
                  // a trapped misaligned access must not write back
                  wwreg  <= mwreg & ~acc;
                  wm2reg <= mm2reg & ~acc;
                  winstr <= minstr;
               end
            end
            WAIT: begin
               wwreg  <= 1'b0;
               wm2reg <= 1'b0;
               winstr <= '0;
               cnt    <= cnt + 8'd1;
               if (dm.dm_ack) begin
                  buf_q     <= dm.dm_rdata;
                  dm.dm_req <= 1'b0;
                  state     <= DONE;
               end else if (cnt == LIM) begin
                  dm.dm_req <= 1'b0;
                  err_q     <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               wwreg    <= mwreg & ~err_q;
               wm2reg   <= mm2reg & ~err_q;
               wmo      <= buf_q;
               walu     <= C_r;
               wrn      <= mrn;
               winstr   <= minstr;
               wbus_err <= err_q;
               err_q    <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected MEM/WB records,
// a negedge monitor pops one whenever an instruction reaches write-back.
module tb_mem_stage;
   localparam int LIM = 6;

   typedef struct {
      logic        wwreg;
      logic        wm2reg;
      logic [31:0] wmo;
      logic [31:0] walu;
      logic [4:0]  wrn;
      logic [31:0] winstr;
      logic        bus;
      logic        align;
      logic        chk_wmo;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mwreg, mm2reg, mwmem;
   logic [31:0] C_r, mb, minstr;
   logic [4:0]  mrn;
   logic        mem_stall, wwreg, wm2reg;
   logic [31:0] wmo, walu, winstr;
   logic [4:0]  wrn;
   logic        wbus_err, walign_err;

   mem_stage_if dmi ();

   mem_stage #(.WAIT_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
      .C_r(C_r), .mb(mb), .mrn(mrn), .minstr(minstr),
      .dm(dmi),
      .mem_stall(mem_stall),
      .wwreg(wwreg), .wm2reg(wm2reg),
      .wmo(wmo), .walu(walu), .wrn(wrn), .winstr(winstr),
      .wbus_err(wbus_err), .walign_err(walign_err)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;
   rec_t q[$];

   function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endfunction

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (winstr != 0 || wbus_err || walign_err) begin
            if (q.size() == 0) begin
               chk("unexpected_wb", winstr, 32'h0);
            end else begin
               rec_t e;
               e = q.pop_front();
               chk("winstr", winstr, e.winstr);
               chk("wwreg", 32'(wwreg), 32'(e.wwreg));
               chk("wm2reg", 32'(wm2reg), 32'(e.wm2reg));
               chk("walu", walu, e.walu);
               chk("wrn", 32'(wrn), 32'(e.wrn));
               chk("wbus_err", 32'(wbus_err), 32'(e.bus));
               chk("walign_err", 32'(walign_err), 32'(e.align));
               if (e.chk_wmo) chk("wmo", wmo, e.wmo);
            end
         end else if (wwreg || wm2reg) begin
            chk("bubble_wwreg", 32'({wwreg, wm2reg}), 32'h0);
         end
      end
   end

   task automatic drive(input logic wr, input logic ld, input logic st,
                        input logic [31:0] c, input logic [31:0] b,
                        input logic [4:0] rn, input logic [31:0] ins);
      mwreg = wr; mm2reg = ld; mwmem = st;
      C_r = c; mb = b; mrn = rn; minstr = ins;
   endtask

   // ack_at: WAIT cycle (1-based) on which memory acks; 0 = never
   task automatic op(input logic wr, input logic ld, input logic st,
                     input logic [31:0] c, input logic [31:0] b,
                     input logic [4:0] rn, input logic [31:0] ins,
                     input int ack_at, input logic [31:0] rdata,
                     input int exp_stall, input logic [31:0] exp_addr,
                     input rec_t r);
      int  stalls;
      int  w;
      bit  done;
      stalls = 0;
      w = 0;
      done = 1'b0;
      @(negedge clk);
      drive(wr, ld, st, c, b, rn, ins);
      q.push_back(r);
      for (int k = 0; k < 40 && !done; k++) begin
         if (k > 0) begin
            @(negedge clk);
            dmi.dm_ack = 1'b0;
         end
         #1;
         if (mem_stall) begin
            stalls++;
            if (dmi.dm_req) begin
               w++;
               if (w == 1) begin
                  chk("dm_addr", dmi.dm_addr, exp_addr);
                  chk("dm_we", 32'(dmi.dm_we), 32'(st));
                  if (st) chk("dm_wdata", dmi.dm_wdata, b);
               end
               if (w == ack_at) begin
                  dmi.dm_ack = 1'b1;
                  dmi.dm_rdata = rdata;
               end
            end
         end else begin
            done = 1'b1;
         end
      end
      if (!done) chk("stall_timeout", 32'(stalls), 32'(exp_stall));
      chk("stall_cycles", 32'(stalls), 32'(exp_stall));
      chk("req_cycles", 32'(w), 32'(exp_stall > 0 ? exp_stall - 1 : 0));
      chk("req_drop", 32'(dmi.dm_req), 32'h0);
   endtask

   function automatic rec_t mk(logic wr, logic ld, logic [31:0] mo,
                               logic [31:0] alu, logic [4:0] rn,
                               logic [31:0] ins, logic bus,
                               logic align, logic cm);
      rec_t r;
      r.wwreg = wr; r.wm2reg = ld; r.wmo = mo; r.walu = alu;
      r.wrn = rn; r.winstr = ins; r.bus = bus; r.align = align;
      r.chk_wmo = cm;
      return r;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      dmi.dm_ack = 1'b0;
      dmi.dm_rdata = '0;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_state", {wwreg, wm2reg, wbus_err, walign_err, mem_stall,
                        dmi.dm_req, dmi.dm_we, wrn}, 32'h0);
      chk("rst_wmo", wmo, 0);
      chk("rst_walu", walu, 0);
      chk("rst_winstr", winstr, 0);
      chk("rst_addr", dmi.dm_addr, 0);
      chk("rst_wdata", dmi.dm_wdata, 0);
      mon_en = 1'b1;

      op(1, 0, 0, 32'h1234, 0, 5, 32'h11, 0, 0, 0, 0,
         mk(1, 0, 0, 32'h1234, 5, 32'h11, 0, 0, 1));
      op(0, 0, 0, 32'hFFFF_FFFC, 0, 31, 32'h88, 0, 0, 0, 0,
         mk(0, 0, 0, 32'hFFFF_FFFC, 31, 32'h88, 0, 0, 1));
      op(1, 1, 0, 32'h100, 0, 8, 32'h22, 1, 32'hDEADBEEF, 2, 32'h100,
         mk(1, 1, 32'hDEADBEEF, 32'h100, 8, 32'h22, 0, 0, 1));
      op(0, 0, 1, 32'h200, 32'hCAFEF00D, 3, 32'h33, 5, 0, 6, 32'h200,
         mk(0, 0, 0, 32'h200, 3, 32'h33, 0, 0, 0));
      op(1, 1, 0, 32'h300, 0, 9, 32'h44, 0, 0, LIM + 1, 32'h300,
         mk(0, 0, 0, 32'h300, 9, 32'h44, 1, 0, 0));
      op(1, 1, 0, 32'h304, 0, 10, 32'h55, LIM, 32'h12345678, LIM + 1,
         32'h304, mk(1, 1, 32'h12345678, 32'h304, 10, 32'h55, 0, 0, 1));
`ifdef MEM_ALIGN_CHECK_EN
      op(1, 1, 0, 32'h102, 0, 11, 32'h66, 1, 32'hA5A5A5A5, 0, 32'h100,
         mk(0, 0, 0, 32'h102, 11, 32'h66, 0, 1, 0));
`else
      op(1, 1, 0, 32'h102, 0, 11, 32'h66, 1, 32'hA5A5A5A5, 2, 32'h100,
         mk(1, 1, 32'hA5A5A5A5, 32'h102, 11, 32'h66, 0, 0, 1));
`endif

      // reset in the 2nd WAIT cycle abandons the request
      @(negedge clk);
      drive(1, 1, 0, 32'h400, 0, 12, 32'h99);
      @(negedge clk);
      #1;
      chk("rst_wait1_req", 32'(dmi.dm_req), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_mid_req", 32'(dmi.dm_req), 32'h0);
      chk("rst_mid_stall", 32'(mem_stall), 32'h0);
      chk("rst_mid_ctl", {wwreg, wm2reg, wbus_err, walign_err, wrn}, 0);
      chk("rst_mid_walu", walu, 0);
      chk("rst_mid_winstr", winstr, 0);

      op(1, 0, 0, 32'hBEEF, 0, 7, 32'h77, 0, 0, 0, 0,
         mk(1, 0, 0, 32'hBEEF, 7, 32'h77, 0, 0, 1));
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
